// File: rtl/switch_input_module_if.sv
// Switch-input producer port bundle: board inputs plus the FIFO write side.
// The master end is the producer, the slave end is the FIFO/board side.
interface switch_input_module_if;
  logic [15:0] sw;
  logic        key_n;
  logic        full;
  logic        wr;
  logic [15:0] output_1;
  logic        busy;
  logic        bcd_error;

  modport master (
    input  sw,
    input  key_n,
    input  full,
    output wr,
    output output_1,
    output busy,
    output bcd_error
  );

  modport slave (
    output sw,
    output key_n,
    output full,
    input  wr,
    input  output_1,
    input  busy,
    input  bcd_error
  );
endinterface

// File: rtl/switch_input_module.sv
// Debounced BCD switch loader: converts sw to binary on a key press
// and issues one FIFO write per accepted value.
module switch_input_module #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  switch_input_module_if.master bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    WRITE
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic [CW-1:0] r_cnt;

  state_t        r_state;
  logic [15:0]   r_snap;
  logic [15:0]   r_acc;
  logic [1:0]    r_idx;
  logic          r_wr;
  logic [15:0]   r_out;
  logic          r_busy;
  logic          r_err;

  logic          w_press;
  logic          w_bad;
  logic [3:0]    w_digit;
  logic [15:0]   w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_deb   <= 1'b1;
      r_deb_d <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= bus.key_n;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign w_press = r_deb_d & ~r_deb;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.sw[i*4 +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  // Most significant digit first: acc*10 + digit, as shift-adds.
  assign w_digit = r_snap[{r_idx, 2'b00} +: 4];
  assign w_next  = (r_acc << 3) + (r_acc << 1) + {12'd0, w_digit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_press) begin
            r_snap <= bus.sw;
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_err   <= 1'b0;
              r_acc   <= '0;
              r_idx   <= 2'd3;
              r_busy  <= 1'b1;
              r_state <= CONVERT;
            end
          end
        end
        CONVERT: begin
          r_acc <= w_next;
          r_idx <= r_idx - 2'd1;
          if (r_idx == 2'd0) begin
            r_out   <= w_next;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (!bus.full) begin
            r_wr    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.wr        = r_wr;
  assign bus.output_1  = r_out;
  assign bus.busy      = r_busy;
  assign bus.bcd_error = r_err;

endmodule

// File: tb/tb_switch_input_module.sv
// Randomized bench for switch_input_module against a decimal model.
// Timing is predicted from key-edge arithmetic, not internal state.
module tb_switch_input_module;

  localparam int DEB = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  switch_input_module_if bus ();

  switch_input_module #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit bcd_ok(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int bcd_val(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 +
           int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic test_reset();
    int nwr;
    int bad;
    nwr = 0;
    bad = 0;
    rst = 1'b1;
    bus.key_n = 1'b1;
    bus.sw = 16'h0000;
    bus.full = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.wr, bus.busy, bus.bcd_error} !== 3'b000 ||
        bus.output_1 !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: wr=%b busy=%b err=%b out=%h want 0",
               bus.wr, bus.busy, bus.bcd_error, bus.output_1);
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.wr === 1'b1) nwr++;
      if (bus.busy !== 1'b0 || bus.output_1 !== 16'h0) bad++;
    end
    tests++;
    if (nwr != 0 || bad != 0) begin
      fails++;
      $display("FAIL reset_idle: wr_pulses=%0d bad_cycles=%0d want 0 0",
               nwr, bad);
    end
  endtask

  task automatic test_press(input logic [15:0] v, input string nm);
    int k;
    int d;
    int nwr;
    int wcyc;
    int bbad;
    bit ok;
    bit eb;
    logic [15:0] wval;
    ok = bcd_ok(v);
    nwr = 0;
    wcyc = -1;
    bbad = -1;
    wval = 'x;
    @(negedge clk);
    bus.sw = v;
    bus.key_n = 1'b0;
    k = cyc + 1;
    d = k + 1 + DEB;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      eb = ok && cyc >= d + 1 && cyc <= d + 5;
      if (bus.busy !== eb && bbad < 0) bbad = cyc - d;
      if (bus.wr === 1'b1) begin
        nwr++;
        wcyc = cyc;
        wval = bus.output_1;
      end
      if (cyc == k + 20) bus.key_n = 1'b1;
    end
    repeat (10) @(negedge clk);
    tests++;
    if (bus.bcd_error !== !ok) begin
      fails++;
      $display("FAIL %s_bcd_error: got %b want %b", nm, bus.bcd_error, !ok);
    end
    tests++;
    if (nwr != (ok ? 1 : 0)) begin
      fails++;
      $display("FAIL %s_wr_count: got %0d want %0d", nm, nwr, ok ? 1 : 0);
    end
    tests++;
    if (bbad >= 0) begin
      fails++;
      $display("FAIL %s_busy: wrong at D+%0d", nm, bbad);
    end
    if (ok) begin
      tests++;
      if (wcyc != d + 6 || wval !== 16'(bcd_val(v))) begin
        fails++;
        $display("FAIL %s_write: at D+%0d val %h want D+6 val %h",
                 nm, wcyc - d, wval, 16'(bcd_val(v)));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 6; n++) begin
      for (int j = 0; j < 4; j++) begin
        v[j*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 2) == 0) begin
        v[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
      end
      test_press(v, "random");
    end
  endtask

  task automatic test_bounce();
    int nwr;
    int nb;
    nwr = 0;
    nb = 0;
    bus.sw = 16'h0321;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus.wr === 1'b1) nwr++;
      if (bus.busy !== 1'b0) nb++;
      if (i < 12) bus.key_n = i[0] ? 1'b1 : 1'b0;
      else if (i < 15) bus.key_n = 1'b0;
      else bus.key_n = 1'b1;
    end
    tests++;
    if (nwr != 0 || nb != 0) begin
      fails++;
      $display("FAIL bounce: wr_pulses=%0d busy_cycles=%0d want 0 0",
               nwr, nb);
    end
  endtask

  task automatic test_full();
    int k;
    int d;
    int nwr;
    int wcyc;
    int bad;
    logic [15:0] v1;
    logic [15:0] wval;
    v1 = 16'h5678;
    nwr = 0;
    wcyc = -1;
    bad = 0;
    wval = 'x;
    @(negedge clk);
    bus.sw = v1;
    bus.key_n = 1'b0;
    bus.full = 1'b1;
    k = cyc + 1;
    d = k + 1 + DEB;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.wr === 1'b1) begin
        nwr++;
        wcyc = cyc;
        wval = bus.output_1;
      end
      if (cyc >= d + 1 && cyc <= d + 20 && bus.busy !== 1'b1) bad++;
      if (cyc >= d + 5 && cyc <= d + 20 &&
          bus.output_1 !== 16'(bcd_val(v1))) bad++;
      if (cyc == d) bus.key_n = 1'b1;
      if (cyc == d + 4) begin
        bus.sw = 16'h0011;
        bus.key_n = 1'b0;
      end
      if (cyc == d + 15) bus.key_n = 1'b1;
      if (cyc == d + 20) bus.full = 1'b0;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL full_hold: %0d cycles with busy/output wrong", bad);
    end
    tests++;
    if (nwr != 1 || wcyc != d + 21 || wval !== 16'(bcd_val(v1))) begin
      fails++;
      $display("FAIL full_release: %0d pulses at D+%0d val %h want 1 D+21 %h",
               nwr, wcyc - d, wval, 16'(bcd_val(v1)));
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int d;
    int nwr;
    nwr = 0;
    @(negedge clk);
    bus.sw = 16'h4321;
    bus.key_n = 1'b0;
    k = cyc + 1;
    d = k + 1 + DEB;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.wr === 1'b1) nwr++;
      if (cyc == d + 2) begin
        rst = 1'b1;
        bus.key_n = 1'b1;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.wr !== 1'b0) begin
          fails++;
          $display("FAIL reset_mid_abort: busy=%b wr=%b want 0 0",
                   bus.busy, bus.wr);
        end
      end
      if (cyc == d + 4) rst = 1'b0;
    end
    tests++;
    if (nwr != 0 || bus.output_1 !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid_after: pulses=%0d out=%h want 0 0000",
               nwr, bus.output_1);
    end
  endtask

  task automatic test_held_reset();
    int nwr;
    logic [15:0] wval;
    nwr = 0;
    wval = 'x;
    @(negedge clk);
    rst = 1'b1;
    bus.key_n = 1'b0;
    bus.sw = 16'h0777;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.wr === 1'b1) begin
        nwr++;
        wval = bus.output_1;
      end
      if (i == 30) bus.key_n = 1'b1;
    end
    repeat (10) @(negedge clk);
    tests++;
    if (nwr != 1 || wval !== 16'd777) begin
      fails++;
      $display("FAIL held_reset: pulses=%0d val=%h want 1 %h",
               nwr, wval, 16'd777);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_press(16'h1234, "p1234");
    test_press(16'h9999, "p9999");
    test_press(16'h0000, "p0000");
    test_press(16'h12A4, "p12A4");
    test_press(16'h0042, "p0042");
    test_random();
    test_bounce();
    test_full();
    test_reset_mid();
    test_held_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
